hazard_forward_ctrl: RTL and testbench



---
 rtl/hazard_forward_ctrl.sv | 179 +++++++++++++++++
 tb/tb_hazard_forward_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_ctrl.sv
// Hazard / forwarding controller for the 5-stage pipeline.
// Per-source forwarding and ID-side hazard matching live in hazard_fwd_lane,
// replicated NUM_SRC times; the top owns the retired-write buffer, the
// multi-cycle unit scoreboard/FSM and the stall combine.
// Optional: define HAZ_PERF_CNT_EN to add saturating stall performance counters.

module hazard_fwd_lane #(
    parameter int AW      = 4,
    parameter bit R0_ZERO = 1'b1
) (
    input  logic [AW-1:0]      ex_src,
    input  logic [AW-1:0]      id_src,
    input  logic               id_src_vld,
    input  logic [AW-1:0]      exmem_rd,
    input  logic               exmem_regwrite,
    input  logic [AW-1:0]      memwb_rd,
    input  logic               memwb_regwrite,
    input  logic [AW-1:0]      ret_rd,
    input  logic               ret_vld,
    input  logic [AW-1:0]      idex_rd,
    input  logic               idex_memread,
    input  logic [2**AW-1:0]   sb,
    output logic [1:0]         fwd_sel,
    output logic               lduse_hit,
    output logic               raw_hit
);
    function automatic logic live(input logic [AW-1:0] a);
        return !R0_ZERO || (a != '0);
    endfunction

    // EX operand source select, newest producer wins
    always_comb begin
        fwd_sel = 2'b00;
        if (exmem_regwrite && exmem_rd == ex_src && live(ex_src))
            fwd_sel = 2'b10;
        else if (memwb_regwrite && memwb_rd == ex_src && live(ex_src))
            fwd_sel = 2'b01;
        else if (ret_vld && ret_rd == ex_src)
            fwd_sel = 2'b11;
    end

    // ID operand hazards: pending load in EX, pending multi-cycle result
    always_comb begin
        lduse_hit = idex_memread && id_src_vld && live(id_src) && (idex_rd == id_src);
        raw_hit   = id_src_vld && live(id_src) && sb[id_src];
    end
endmodule

module hazard_forward_ctrl #(
    parameter int AW      = 4,
    parameter int NUM_SRC = 2,
    parameter bit R0_ZERO = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_SRC*AW-1:0]  id_src,
    input  logic [NUM_SRC-1:0]     id_src_vld,
    input  logic [AW-1:0]          id_rd,
    input  logic                   id_regwrite,
    input  logic                   id_lu_op,
    input  logic [NUM_SRC*AW-1:0]  ex_src,
    input  logic [AW-1:0]          idex_rd,
    input  logic                   idex_memread,
    input  logic [AW-1:0]          exmem_rd,
    input  logic                   exmem_regwrite,
    input  logic [AW-1:0]          memwb_rd,
    input  logic                   memwb_regwrite,
    input  logic                   lu_issue,
    input  logic [AW-1:0]          lu_rd,
    input  logic                   lu_wb,
    output logic [NUM_SRC*2-1:0]   fwd_sel,
    output logic                   stall,
    output logic                   idex_bubble,
`ifdef HAZ_PERF_CNT_EN
    output logic [31:0]            perf_stall_cnt,
    output logic [31:0]            perf_lu_stall_cnt,
`endif
    output logic                   lu_busy
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} lu_state_t;

    lu_state_t             state;
    logic [2**AW-1:0]      sb;
    logic [AW-1:0]         pend_rd;
    logic                  ret_vld;
    logic [AW-1:0]         ret_rd;
    logic [NUM_SRC-1:0]    lduse_hit;
    logic [NUM_SRC-1:0]    raw_hit;
    logic                  lduse_haz;
    logic                  sb_haz;
    logic                  struct_haz;
    logic                  issue_ok;

    function automatic logic live(input logic [AW-1:0] a);
        return !R0_ZERO || (a != '0);
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_lane
            hazard_fwd_lane #(.AW(AW), .R0_ZERO(R0_ZERO)) u_lane (
                .ex_src         (ex_src[gi*AW +: AW]),
                .id_src         (id_src[gi*AW +: AW]),
                .id_src_vld     (id_src_vld[gi]),
                .exmem_rd       (exmem_rd),
                .exmem_regwrite (exmem_regwrite),
                .memwb_rd       (memwb_rd),
                .memwb_regwrite (memwb_regwrite),
                .ret_rd         (ret_rd),
                .ret_vld        (ret_vld),
                .idex_rd        (idex_rd),
                .idex_memread   (idex_memread),
                .sb             (sb),
                .fwd_sel        (fwd_sel[gi*2 +: 2]),
                .lduse_hit      (lduse_hit[gi]),
                .raw_hit        (raw_hit[gi])
            );
        end
    endgenerate

    // Hazard combine; an issue while busy is only accepted alongside the writeback
    always_comb begin
        issue_ok    = lu_issue && (state == IDLE || lu_wb);
        lduse_haz   = |lduse_hit;
        sb_haz      = (|raw_hit) || (id_regwrite && live(id_rd) && sb[id_rd]);
        struct_haz  = id_lu_op && (state == BUSY) && !lu_wb;
        stall       = lduse_haz || sb_haz || struct_haz;
        idex_bubble = stall;
        lu_busy     = (state == BUSY);
    end

    // Retired-write buffer: covers the regfile write landing at end of cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ret_vld <= 1'b0;
            ret_rd  <= '0;
        end else begin
            ret_vld <= memwb_regwrite && live(memwb_rd);
            ret_rd  <= memwb_rd;
        end
    end

    // Multi-cycle unit FSM and scoreboard; clear-then-set keeps a reissued rd set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sb      <= '0;
            pend_rd <= '0;
        end else begin
            if (lu_wb && state == BUSY)
                sb[pend_rd] <= 1'b0;
            if (issue_ok) begin
                if (live(lu_rd))
                    sb[lu_rd] <= 1'b1;
                pend_rd <= lu_rd;
            end
            case (state)
                IDLE:    if (lu_issue) state <= BUSY;
                BUSY:    if (lu_wb)    state <= lu_issue ? BUSY : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef HAZ_PERF_CNT_EN
    // Saturating stall-cycle counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt    <= '0;
            perf_lu_stall_cnt <= '0;
        end else begin
            if (stall && perf_stall_cnt != '1)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if ((sb_haz || struct_haz) && perf_lu_stall_cnt != '1)
                perf_lu_stall_cnt <= perf_lu_stall_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Scoreboard bench for hazard_forward_ctrl: the driver applies one stimulus
// per cycle and queues the reference model's expected outputs; the monitor
// pops and compares on the falling edge.
module tb_hazard_forward_ctrl;
    localparam int AW  = 4;
    localparam int NS  = 2;
    localparam bit R0Z = 1'b1;

    typedef struct {
        bit rst_n;
        int id_src[NS];
        bit id_vld[NS];
        int id_rd;
        bit id_regwrite, id_lu_op;
        int ex_src[NS];
        int idex_rd;
        bit idex_memread;
        int exmem_rd;
        bit exmem_regwrite;
        int memwb_rd;
        bit memwb_regwrite;
        bit lu_issue;
        int lu_rd;
        bit lu_wb;
    } stim_t;

    typedef struct {
        int  fwd[NS];
        bit  stall;
        bit  busy;
        longint pcnt, plcnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [NS*AW-1:0] id_src, ex_src;
    logic [NS-1:0]    id_src_vld;
    logic [AW-1:0]    id_rd, idex_rd, exmem_rd, memwb_rd, lu_rd;
    logic id_regwrite, id_lu_op, idex_memread, exmem_regwrite, memwb_regwrite, lu_issue, lu_wb;
    logic [NS*2-1:0]  fwd_sel;
    logic stall, idex_bubble, lu_busy;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] perf_stall_cnt, perf_lu_stall_cnt;
`endif

    hazard_forward_ctrl #(.AW(AW), .NUM_SRC(NS), .R0_ZERO(R0Z)) dut (
        .clk(clk), .rst_n(rst_n), .id_src(id_src), .id_src_vld(id_src_vld),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_lu_op(id_lu_op),
        .ex_src(ex_src), .idex_rd(idex_rd), .idex_memread(idex_memread),
        .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite),
        .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite),
        .lu_issue(lu_issue), .lu_rd(lu_rd), .lu_wb(lu_wb),
        .fwd_sel(fwd_sel), .stall(stall), .idex_bubble(idex_bubble),
`ifdef HAZ_PERF_CNT_EN
        .perf_stall_cnt(perf_stall_cnt), .perf_lu_stall_cnt(perf_lu_stall_cnt),
`endif
        .lu_busy(lu_busy)
    );

    always #5 clk = ~clk;

    // Reference model state: the in-flight long op and the last retired write
    bit     m_busy;
    int     m_pend;      // register the in-flight op will write, -1 if none
    bit     m_ret_vld;
    int     m_ret_rd;
    longint m_pcnt, m_plcnt;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    function automatic bit live(int a);
        return !R0Z || a != 0;
    endfunction

    function automatic void model_reset();
        m_busy = 0; m_pend = -1; m_ret_vld = 0; m_ret_rd = 0;
        m_pcnt = 0; m_plcnt = 0;
    endfunction

    function automatic stim_t idle_stim();
        stim_t s;
        s.rst_n = 1;
        for (int i = 0; i < NS; i++) begin
            s.id_src[i] = 0; s.id_vld[i] = 0; s.ex_src[i] = 0;
        end
        s.id_rd = 0; s.id_regwrite = 0; s.id_lu_op = 0;
        s.idex_rd = 0; s.idex_memread = 0;
        s.exmem_rd = 0; s.exmem_regwrite = 0;
        s.memwb_rd = 0; s.memwb_regwrite = 0;
        s.lu_issue = 0; s.lu_rd = 0; s.lu_wb = 0;
        return s;
    endfunction

    // Drive one cycle, queue the expected outputs, then advance the model
    task automatic apply(input stim_t s);
        exp_t e;
        bit lduse, sbh, strh;
        @(posedge clk);
        #1;
        rst_n = s.rst_n;
        for (int i = 0; i < NS; i++) begin
            id_src[i*AW +: AW] = AW'(s.id_src[i]);
            ex_src[i*AW +: AW] = AW'(s.ex_src[i]);
            id_src_vld[i]      = s.id_vld[i];
        end
        id_rd = AW'(s.id_rd); id_regwrite = s.id_regwrite; id_lu_op = s.id_lu_op;
        idex_rd = AW'(s.idex_rd); idex_memread = s.idex_memread;
        exmem_rd = AW'(s.exmem_rd); exmem_regwrite = s.exmem_regwrite;
        memwb_rd = AW'(s.memwb_rd); memwb_regwrite = s.memwb_regwrite;
        lu_issue = s.lu_issue; lu_rd = AW'(s.lu_rd); lu_wb = s.lu_wb;

        if (!s.rst_n) model_reset();
        lduse = 0; sbh = 0;
        for (int i = 0; i < NS; i++) begin
            int a = s.ex_src[i];
            int b = s.id_src[i];
            if (s.exmem_regwrite && s.exmem_rd == a && live(a))      e.fwd[i] = 2;
            else if (s.memwb_regwrite && s.memwb_rd == a && live(a)) e.fwd[i] = 1;
            else if (m_ret_vld && m_ret_rd == a)                     e.fwd[i] = 3;
            else                                                     e.fwd[i] = 0;
            if (s.id_vld[i] && live(b) && s.idex_memread && s.idex_rd == b) lduse = 1;
            if (s.id_vld[i] && live(b) && b == m_pend) sbh = 1;
        end
        if (s.id_regwrite && live(s.id_rd) && s.id_rd == m_pend) sbh = 1;
        strh    = s.id_lu_op && m_busy && !s.lu_wb;
        e.stall = lduse || sbh || strh;
        e.busy  = m_busy;
        e.pcnt  = m_pcnt;
        e.plcnt = m_plcnt;
        exp_q.push_back(e);

        if (s.rst_n) begin
            if (e.stall) m_pcnt++;
            if (sbh || strh) m_plcnt++;
            m_ret_vld = s.memwb_regwrite && live(s.memwb_rd);
            m_ret_rd  = s.memwb_rd;
            if (s.lu_issue && (!m_busy || s.lu_wb)) begin
                m_busy = 1;
                m_pend = live(s.lu_rd) ? s.lu_rd : -1;
            end else if (s.lu_wb && m_busy) begin
                m_busy = 0;
                m_pend = -1;
            end
        end
    endtask

    // Monitor: outputs are combinational, so every driven cycle presents a result
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                vectors++;
                for (int i = 0; i < NS; i++)
                    if (int'(fwd_sel[i*2 +: 2]) != e.fwd[i]) begin
                        miscompares++;
                        $display("FAIL fwd_sel[%0d] @%0t: got %0d want %0d", i, $time, fwd_sel[i*2 +: 2], e.fwd[i]);
                    end
                if (stall !== e.stall) begin
                    miscompares++;
                    $display("FAIL stall @%0t: got %b want %b", $time, stall, e.stall);
                end
                if (idex_bubble !== e.stall) begin
                    miscompares++;
                    $display("FAIL idex_bubble @%0t: got %b want %b", $time, idex_bubble, e.stall);
                end
                if (lu_busy !== e.busy) begin
                    miscompares++;
                    $display("FAIL lu_busy @%0t: got %b want %b", $time, lu_busy, e.busy);
                end
`ifdef HAZ_PERF_CNT_EN
                if (longint'(perf_stall_cnt) != e.pcnt) begin
                    miscompares++;
                    $display("FAIL perf_stall_cnt @%0t: got %0d want %0d", $time, perf_stall_cnt, e.pcnt);
                end
                if (longint'(perf_lu_stall_cnt) != e.plcnt) begin
                    miscompares++;
                    $display("FAIL perf_lu_stall_cnt @%0t: got %0d want %0d", $time, perf_lu_stall_cnt, e.plcnt);
                end
`endif
            end
        end
    end

    initial begin
        stim_t s;
        model_reset();
        rst_n = 0;
        id_src = '0; ex_src = '0; id_src_vld = '0; id_rd = '0; idex_rd = '0;
        exmem_rd = '0; memwb_rd = '0; lu_rd = '0;
        id_regwrite = 0; id_lu_op = 0; idex_memread = 0; exmem_regwrite = 0;
        memwb_regwrite = 0; lu_issue = 0; lu_wb = 0;

        // Reset state with all-zero inputs
        s = idle_stim(); s.rst_n = 0;
        apply(s); apply(s);
        s = idle_stim(); apply(s);

        // EX/MEM wins over MEM/WB on the same register
        s = idle_stim();
        s.exmem_regwrite = 1; s.exmem_rd = 3; s.memwb_regwrite = 1; s.memwb_rd = 3;
        s.ex_src[0] = 3; s.ex_src[1] = 5;
        apply(s);

        // Retired buffer: one-cycle window, and never for r0
        for (int r = 0; r < 2; r++) begin
            s = idle_stim(); s.memwb_regwrite = 1; s.memwb_rd = (r == 0) ? 7 : 0;
            apply(s);
            s = idle_stim(); s.ex_src[0] = (r == 0) ? 7 : 0;
            apply(s); apply(s);
        end

        // Load-use: only a valid operand triggers it
        s = idle_stim();
        s.idex_memread = 1; s.idex_rd = 4; s.id_src[1] = 4; s.id_vld[1] = 1;
        apply(s);
        s.id_vld[1] = 0;
        apply(s);

        // Long op to r9, consumer waits until the cycle after writeback
        s = idle_stim(); s.lu_issue = 1; s.lu_rd = 9;
        apply(s);
        for (int c = 1; c <= 6; c++) begin
            s = idle_stim(); s.id_src[0] = 9; s.id_vld[0] = 1;
            s.lu_wb = (c == 5);
            apply(s);
        end

        // Structural hazard, then back-to-back wb+issue to r2
        s = idle_stim(); s.lu_issue = 1; s.lu_rd = 11; apply(s);
        s = idle_stim(); s.id_lu_op = 1; apply(s);
        s = idle_stim(); s.id_lu_op = 1; s.lu_wb = 1; s.lu_issue = 1; s.lu_rd = 2; apply(s);
        s = idle_stim(); s.id_src[0] = 2; s.id_vld[0] = 1; s.id_src[1] = 11; s.id_vld[1] = 1; apply(s);
        s = idle_stim(); s.id_regwrite = 1; s.id_rd = 2; apply(s);
        s = idle_stim(); s.lu_wb = 1; apply(s);
        s = idle_stim(); s.id_src[0] = 2; s.id_vld[0] = 1; apply(s);

        // Reset mid-operation abandons the r9 op
        s = idle_stim(); s.lu_issue = 1; s.lu_rd = 9; apply(s);
        s = idle_stim(); s.id_src[0] = 9; s.id_vld[0] = 1; apply(s);
        s.rst_n = 0; apply(s);
        s.rst_n = 1; apply(s);

        // Randomized traffic over a small register window to provoke matches
        for (int n = 0; n < 600; n++) begin
            s = idle_stim();
            s.rst_n = ($urandom_range(0, 79) != 0);
            for (int i = 0; i < NS; i++) begin
                s.id_src[i] = $urandom_range(0, 4);
                s.id_vld[i] = $urandom_range(0, 1);
                s.ex_src[i] = $urandom_range(0, 4);
            end
            s.id_rd = $urandom_range(0, 4);
            s.id_regwrite = $urandom_range(0, 1);
            s.id_lu_op = ($urandom_range(0, 3) == 0);
            s.idex_rd = $urandom_range(0, 4);
            s.idex_memread = ($urandom_range(0, 2) == 0);
            s.exmem_rd = $urandom_range(0, 4);
            s.exmem_regwrite = $urandom_range(0, 1);
            s.memwb_rd = $urandom_range(0, 4);
            s.memwb_regwrite = $urandom_range(0, 1);
            s.lu_issue = ($urandom_range(0, 4) == 0);
            s.lu_rd = $urandom_range(0, 4);
            s.lu_wb = ($urandom_range(0, 4) == 0);
            apply(s);
        end

        // Let the monitor drain, bounded
        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d results left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
